// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmit-queue FSM states and a
// constant-foldable ceiling log2 used to size pointers and counters.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        TXQ_IDLE   = 2'd0,
        TXQ_ISSUE  = 2'd1,
        TXQ_ACTIVE = 2'd2
    } txq_state_e;

    function automatic int uart_log2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the transmit queue: one synchronous write port and one
// asynchronous read port, no reset so it maps onto distributed RAM.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = uart_log2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic [AW-1:0]          rd_addr,
    output logic [UART_DATA_W-1:0] rd_data
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART transmitter over TXSTART/LINEIN/BUSY.
// Optional drop counter port enabled by defining UART_TXQ_STATS_EN.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12,
    localparam int AW         = uart_log2(DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   afull,
    output logic                   empty,
    output logic [LW-1:0]          level,
    output logic                   idle,
    output logic                   txstart,
    output logic [UART_DATA_W-1:0] linein,
    input  logic                   busy
`ifdef UART_TXQ_STATS_EN
    ,
    output logic [7:0]             drops
`endif
);

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   full_q, full_d;
    logic                   afull_q, afull_d;
    logic                   empty_q, empty_d;
    txq_state_e             state_q;
    logic                   txstart_q;
    logic [UART_DATA_W-1:0] linein_q;
    logic [UART_DATA_W-1:0] head;
    logic                   push;
    logic                   pop;

    // A push seen while full is dropped even if a pop frees a slot this cycle.
    assign push = wr_en && !full_q;
    assign pop  = (state_q == TXQ_ACTIVE) && !busy;

    uart_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr_q),
        .wr_data(wr_data),
        .rd_addr(rd_ptr_q),
        .rd_data(head)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        full_d  = (level_d == LW'(DEPTH));
        afull_d = (level_d >= LW'(AFULL_LEVEL));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
        end
    end

    // LINEIN is loaded only when leaving IDLE; the transmitter samples it live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TXQ_IDLE;
            txstart_q <= 1'b0;
            linein_q  <= '0;
        end else begin
            case (state_q)
                TXQ_IDLE: begin
                    if (!empty_q && !busy) begin
                        state_q   <= TXQ_ISSUE;
                        txstart_q <= 1'b1;
                        linein_q  <= head;
                    end
                end
                TXQ_ISSUE: begin
                    if (busy) begin
                        state_q   <= TXQ_ACTIVE;
                        txstart_q <= 1'b0;
                    end
                end
                TXQ_ACTIVE: begin
                    if (!busy) begin
                        state_q <= TXQ_IDLE;
                    end
                end
                default: begin
                    state_q   <= TXQ_IDLE;
                    txstart_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TXQ_STATS_EN
    logic [7:0] drops_q, drops_d;

    always_comb begin
        drops_d = drops_q;
        if (wr_en && full_q && (drops_q != 8'hFF)) begin
            drops_d = drops_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drops_q <= 8'h00;
        end else begin
            drops_q <= drops_d;
        end
    end

    assign drops = drops_q;
`endif

    assign full    = full_q;
    assign afull   = afull_q;
    assign empty   = empty_q;
    assign level   = level_q;
    assign txstart = txstart_q;
    assign linein  = linein_q;
    assign idle    = empty_q && (state_q == TXQ_IDLE) && !busy;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a behavioural transmitter drives BUSY and a serial
// line, a receiver-side monitor checks decoded frames against a scoreboard.
module tb_uart_tx_queue;

    localparam int DEPTH       = 16;
    localparam int AFULL_LEVEL = 12;
    localparam int BIT_CYC     = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ext_busy = 1'b0;
    logic       busy;
    logic       full, afull, empty, idle, txstart;
    logic [4:0] level;
    logic [7:0] linein;
`ifdef UART_TXQ_STATS_EN
    logic [7:0] drops;
`endif

    // Reference model state: stored bytes and counts in plain queue terms.
    logic [7:0] exp_q[$];
    int         m_size = 0;
    int         m_drops = 0;
    bit         inflight = 1'b0;
    int         epoch = 0;
    bit         mon_en = 1'b0;
    bit         check_gap = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic [3:0] tx_bit = 4'd0;
    logic [1:0] tx_cyc = 2'd0;
    logic       txd;

    always #5 clk = ~clk;

    assign busy = tx_busy | ext_busy;

    uart_tx_queue #(
        .DEPTH      (DEPTH),
        .AFULL_LEVEL(AFULL_LEVEL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .afull  (afull),
        .empty  (empty),
        .level  (level),
        .idle   (idle),
        .txstart(txstart),
        .linein (linein),
        .busy   (busy)
`ifdef UART_TXQ_STATS_EN
        ,
        .drops  (drops)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transmitter: start, 8 data bits LSB first, 2 stop bits, reading LINEIN live.
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (!tx_busy) begin
            if (txstart && !ext_busy) begin
                tx_busy <= 1'b1;
                tx_bit  <= 4'd0;
                tx_cyc  <= 2'd0;
            end
        end else if (tx_cyc == 2'(BIT_CYC - 1)) begin
            tx_cyc <= 2'd0;
            if (tx_bit == 4'd10) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
            end else begin
                tx_bit <= tx_bit + 4'd1;
            end
        end else begin
            tx_cyc <= tx_cyc + 2'd1;
        end
    end

    always_comb begin
        txd = 1'b1;
        if (tx_busy) begin
            if (tx_bit == 4'd0) begin
                txd = 1'b0;
            end else if (tx_bit <= 4'd8) begin
                txd = linein[3'(tx_bit - 4'd1)];
            end
        end
    end

    // Model: accepted pushes enter the queue; the head leaves the cycle after its frame ends.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_size   = 0;
            m_drops  = 0;
            inflight = 1'b0;
        end else begin
            if (wr_en && m_size == DEPTH && m_drops < 255) m_drops = m_drops + 1;
            if (wr_en && m_size < DEPTH) begin
                exp_q.push_back(wr_data);
                m_size = m_size + 1;
            end
            if (inflight && tx_done) begin
                inflight = 1'b0;
                m_size   = m_size - 1;
            end
            if (txstart && !busy) inflight = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("level", 32'(level), 32'(m_size));
            checkOutput("full", 32'(full), 32'(m_size == DEPTH));
            checkOutput("afull", 32'(afull), 32'(m_size >= AFULL_LEVEL));
            checkOutput("empty", 32'(empty), 32'(m_size == 0));
            checkOutput("idle", 32'(idle), 32'((m_size == 0) && !busy));
`ifdef UART_TXQ_STATS_EN
            checkOutput("drops", 32'(drops), 32'(m_drops));
`endif
        end
    end

    // Serial monitor: decodes each frame mid-bit and compares with the scoreboard.
    int         mon_ep;
    logic [7:0] mon_data;
    logic [7:0] mon_first;
    bit         mon_fmt;
    bit         mon_stable;
    initial forever begin
        @(posedge tx_busy);
        mon_ep = epoch;
        repeat (BIT_CYC / 2) @(negedge clk);
        mon_first  = linein;
        mon_fmt    = (txd == 1'b0);
        mon_stable = 1'b1;
        mon_data   = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            repeat (BIT_CYC) @(negedge clk);
            if (k <= 8) mon_data[k-1] = txd;
            else if (txd !== 1'b1) mon_fmt = 1'b0;
            if (linein !== mon_first) mon_stable = 1'b0;
        end
        if (mon_ep == epoch) begin
            checkOutput("frame_format", 32'(mon_fmt), 32'd1);
            checkOutput("linein_stable", 32'(mon_stable), 32'd1);
            if (exp_q.size() == 0) checkOutput("frame_unexpected", 32'(mon_data), 32'hFFFF_FFFF);
            else checkOutput("frame_data", 32'(mon_data), 32'(exp_q.pop_front()));
        end
    end

    // Between back-to-back frames: two low TXSTART samples, then TXSTART high.
    logic [2:0] gap_seq;
    initial forever begin
        @(negedge tx_busy);
        if (check_gap && m_size >= 2) begin
            @(negedge clk) gap_seq[2] = txstart;
            @(negedge clk) gap_seq[1] = txstart;
            @(negedge clk) gap_seq[0] = txstart;
            checkOutput("frame_gap", 32'(gap_seq), 32'h1);
        end
    end

    task automatic applyStimulus(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic applyReset();
        int guard = 0;
        while (tx_busy && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (tx_busy) checkOutput("reset_wait_tx", 32'(tx_busy), 32'd0);
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        ext_busy = 1'b0;
        rst_n    = 1'b0;
        epoch++;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        int guard = 0;
        while (!(idle && !tx_busy && exp_q.size() == 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(name, 32'(idle && exp_q.size() == 0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitFrameEnd();
        int guard = 0;
        while (!tx_done && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!tx_done) checkOutput("frame_end_timeout", 32'(tx_done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values and a single frame with the one-cycle issue latency.
        applyReset();
        @(negedge clk);
        checkOutput("rst_txstart", 32'(txstart), 32'd0);
        checkOutput("rst_linein", 32'(linein), 32'h00);
        wr_en   = 1'b1;
        wr_data = 8'hB6;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        checkOutput("push_txstart_early", 32'(txstart), 32'd0);
        @(negedge clk);
        checkOutput("push_txstart", 32'(txstart), 32'd1);
        checkOutput("push_linein", 32'(linein), 32'hB6);
        waitDrain("drain_single");

        // Burst to full, order and gaps, then a rejected push on the pop edge.
        applyReset();
        check_gap = 1'b1;
        for (int i = 1; i <= 16; i++) applyStimulus(8'(i));
        @(negedge clk);
        checkOutput("burst_level", 32'(level), 32'd16);
        checkOutput("burst_full", 32'(full), 32'd1);
        waitFrameEnd();
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        checkOutput("full_pop_level", 32'(level), 32'd15);
`ifdef UART_TXQ_STATS_EN
        checkOutput("full_pop_drops", 32'(drops), 32'd1);
`endif
        waitDrain("drain_burst");
        check_gap = 1'b0;

        // Pointer wrap with push and pop on the same edge at level 3.
        applyReset();
        for (int i = 0; i < 13; i++) applyStimulus(8'(8'h20 + i));
        waitDrain("drain_prewrap");
        for (int i = 0; i < 3; i++) applyStimulus(8'(8'hC0 + i));
        for (int i = 3; i < 5; i++) begin
            waitFrameEnd();
            wr_en   = 1'b1;
            wr_data = 8'(8'hC0 + i);
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            @(negedge clk);
            checkOutput("wrap_level", 32'(level), 32'd3);
        end
        waitDrain("drain_wrap");

        // Reset mid-frame with five bytes queued.
        applyReset();
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h70 + i));
        repeat (10) @(negedge clk);
        checkOutput("midrst_busy", 32'(tx_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        epoch++;
        #1;
        checkOutput("midrst_level", 32'(level), 32'd0);
        checkOutput("midrst_txstart", 32'(txstart), 32'd0);
        checkOutput("midrst_linein", 32'(linein), 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(8'hA5);
        for (int g = 0; g < 100 && tx_busy; g++) begin
            @(negedge clk);
            checkOutput("midrst_hold", 32'(txstart), 32'd0);
        end
        waitDrain("drain_midrst");

        // Foreign BUSY held high blocks issue until it drops.
        applyReset();
        ext_busy = 1'b1;
        applyStimulus(8'h55);
        repeat (8) begin
            @(negedge clk);
            checkOutput("ext_hold", 32'(txstart), 32'd0);
        end
        @(posedge clk);
        #1;
        ext_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("ext_issue", 32'(txstart), 32'd1);
        checkOutput("ext_linein", 32'(linein), 32'h55);
        waitDrain("drain_ext");

        // Random traffic, then a long push hold so the drop count saturates.
        applyReset();
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 1) == 0);
            wr_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wr_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        waitDrain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte FIFO and issue controller that sits directly upstream of the UART `Transmitter`. It accepts bytes from the processor side at full clock rate, buffers them, and feeds the transmitter one frame at a time over its `TXSTART`/`LINEIN`/`BUSY` handshake. It holds `LINEIN` stable for the whole frame, because the transmitter's data mux reads `LINEIN` live.

## Interface
- `DEPTH`, 16: FIFO entries; power of 2, ≥2.
- `AFULL_LEVEL`, 12: `AFULL` asserts when LEVEL ≥ this value; range 1..DEPTH.
- `CLOCK` in 1: single clock. The transmitter runs on the same `CLOCK`.
- `RESETN` in 1: reset, asynchronous assert, active-low.
- `WR_EN` in 1: push request.
- `WR_DATA` in 8: byte to push.
- `FULL` out 1: LEVEL == DEPTH.
- `AFULL` out 1: LEVEL ≥ AFULL_LEVEL.
- `EMPTY` out 1: LEVEL == 0.
- `LEVEL` out log2(DEPTH)+1: stored entries, including the byte currently being sent.
- `IDLE` out 1: high when EMPTY, state IDLE and BUSY low.
- `TXSTART` out 1: to transmitter `TXSTART`.
- `LINEIN` out 8: to transmitter `LINEIN`.
- `BUSY` in 1: from transmitter `BUSY`.
- `DROPS` out 8: rejected-push count. Present only with `UART_TXQ_STATS_EN`.

## Operation
- Storage: DEPTH×8 RAM with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a LEVEL counter.
- Push: accepted when WR_EN=1 and FULL=0 in the same cycle.
  - A push while FULL is discarded, even if a pop occurs that cycle.
  - A discarded push never corrupts stored data.
- Pop: the head entry is removed only when its frame completes (ACTIVE→IDLE). A push and a pop in the same cycle leave LEVEL unchanged.
- FSM states, all outputs registered:
  - IDLE: TXSTART=0. If EMPTY=0 and BUSY=0, load LINEIN ← head and go to ISSUE.
  - ISSUE: TXSTART=1, LINEIN=head. Stay while BUSY=0. On BUSY=1, go to ACTIVE.
  - ACTIVE: TXSTART=0, LINEIN held. On BUSY=0, pop, advance the read pointer and go to IDLE.
- IDLE enforces at least one idle cycle between frames. The transmitter's two stop bits supply the line gap.
- Reset values: all pointers and LEVEL 0, state IDLE, TXSTART=0, LINEIN=8'h00, FULL=0, AFULL=0, EMPTY=1, DROPS=0.
- Reset mid-frame: the queue is flushed and outputs go to their reset values. The transmitter finishes its current frame on its own. After RESETN deasserts, no issue happens until BUSY=0 (IDLE guard).
- BUSY already high in IDLE (a foreign or leftover frame): the controller waits and does not issue.

## Timing
- Push at edge N: EMPTY falls and LEVEL increments after edge N.
- Empty queue, BUSY=0: push at edge N → IDLE sees EMPTY=0 at edge N+1 → TXSTART=1 and LINEIN valid after N+1.
  - The transmitter registers start at N+2. BUSY rises after N+2.
  - TXSTART drops after N+3.
  - Push-to-TXSTART latency is 1 cycle.
- LINEIN changes only on the IDLE→ISSUE transition. It is constant from TXSTART rise until the cycle after BUSY falls.
- FULL, AFULL, EMPTY and LEVEL are registered and change one edge after the causing push or pop.
- Pop-to-next-TXSTART: BUSY falls → ACTIVE→IDLE at the next edge → ISSUE one edge later.
- DROPS saturates at 8'hFF.

## Configuration
- `UART_TXQ_STATS_EN` defined:
  - `DROPS` port exists.
  - Each cycle with WR_EN=1 and FULL=1 increments it, saturating.
  - Cleared only by reset.
- `UART_TXQ_STATS_EN` undefined: the port and counter are absent. Rejected pushes are silently discarded.

## Structure
- Shared package `uart_pkg`:
  - UART_DATA_W=8.
  - FSM state encoding localparams TXQ_IDLE/TXQ_ISSUE/TXQ_ACTIVE.
  - A log2 function, replacing per-module copies.
- One sub-module `uart_fifo_mem`: the DEPTH×8 storage with one synchronous write port and one asynchronous read port. Pointer and LEVEL logic stay in `uart_tx_queue`.

## Test plan
- Reset, then push 8'hB6 with BUSY modelled by the real `Transmitter`.
  - TXSTART high 1 cycle after the push.
  - LINEIN=8'hB6 until BUSY falls.
  - Serial DATA shows start bit, then 0,1,1,0,1,1,0,1, then stop bits.
  - EMPTY=1 afterwards.
- Burst-push 8'h01..8'h10 (DEPTH=16) in consecutive cycles.
  - FULL after the 16th push.
  - AFULL after the 12th.
  - Frames are emitted in order 01..10.
  - Exactly one IDLE cycle between frames.
- Push while FULL, including a cycle where a pop coincides.
  - Byte discarded.
  - LEVEL becomes 15 (pop only).
  - DROPS=1 with the macro defined.
- Push and pop on the same edge at LEVEL=3: LEVEL stays 3 and the pointer wrap past index 15 is correct.
- Assert RESETN mid-frame with 5 bytes queued.
  - LEVEL=0 and TXSTART=0 immediately.
  - A push after release is not issued until BUSY=0.
- Hold BUSY=1 externally while pushing 8'h55: TXSTART stays 0 until BUSY=0, then the frame is issued.
